lsm_sequencer: RTL and testbench

Multi-register transfer sequencer for the Thumb core. After the decoder resolves STM, LDM, PUSH or POP, the issue stage hands the register list, base register and base value to this block. It then runs one word transfer per listed register over the data-memory handshake. It drives the register-file port for each transfer and performs the final base-register writeback. The pipeline stalls on `busy`.

---
 rtl/lsm_seq_pkg.sv | 30 +++
 rtl/lsm_sequencer_scan.sv | 29 ++
 rtl/lsm_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_lsm_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_seq_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
package lsm_seq_pkg;

  localparam int unsigned MASK_W    = 9;
  localparam int unsigned REG_IDX_W = 4;

  typedef enum logic [1:0] {
    STM  = 2'b00,
    LDM  = 2'b01,
    PUSH = 2'b10,
    POP  = 2'b11
  } lsm_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    WB   = 2'b10,
    DONE = 2'b11
  } lsm_state_t;

  localparam logic [REG_IDX_W-1:0] SP_IDX = 4'd13;
  localparam logic [REG_IDX_W-1:0] LR_IDX = 4'd14;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

  // Store-type operations read the register file and write memory.
  function automatic logic is_store(lsm_op_t op);
    return (op == STM) || (op == PUSH);
  endfunction

endpackage

// File: rtl/lsm_sequencer_scan.sv
// Register-list scanner: lowest pending register, pending count, empty flag.
module reg_list_scan
  import lsm_seq_pkg::*;
(
  input  logic [MASK_W-1:0]    mask,
  input  lsm_op_t              op,
  output logic [REG_IDX_W-1:0] idx,
  output logic [REG_IDX_W-1:0] cnt,
  output logic                 empty
);

  // Walk high to low so the lowest set bit is the last one to claim idx.
  always_comb begin
    idx   = '0;
    cnt   = '0;
    empty = (mask == '0);
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        if (i == MASK_W - 1) begin
          idx = (op == POP) ? PC_IDX : LR_IDX;
        end else begin
          idx = REG_IDX_W'(i);
        end
        cnt = cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Multi-register transfer sequencer (STM/LDM/PUSH/POP).
// Optional: define LSM_SEQ_FAULT_EN to add mem_err/fault abort handling.
module lsm_sequencer
  import lsm_seq_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [7:0]    reg_list,
  input  logic          ext_bit,
  input  logic [3:0]    base_idx,
  input  logic [AW-1:0] base_val,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
`ifdef LSM_SEQ_FAULT_EN
  input  logic          mem_err,
  output logic          fault,
`endif
  output logic [3:0]    rf_raddr,
  input  logic [31:0]   rf_rdata,
  output logic          rf_we,
  output logic [3:0]    rf_waddr,
  output logic [31:0]   rf_wdata
);

  localparam int unsigned DW = 32;

  lsm_state_t            state;
  lsm_op_t               op_in;
  lsm_op_t               op_q;
  logic [MASK_W-1:0]     rem;
  logic [MASK_W-1:0]     rem_next;
  logic [MASK_W-1:0]     scan_mask;
  lsm_op_t               scan_op;
  logic [REG_IDX_W-1:0]  scan_idx;
  logic [REG_IDX_W-1:0]  scan_cnt;
  logic                  scan_empty;
  logic [AW-1:0]         span;
  logic [AW-1:0]         final_base;
  logic [3:0]            base_idx_q;
  logic                  wb_allow;
  logic                  wb_we;
  logic [3:0]            wb_addr;
  logic [DW-1:0]         wb_data;
  logic                  ack_err;
  logic                  load_we;
  logic                  ext_eff;

  assign op_in   = lsm_op_t'(op);
  assign ext_eff = ext_bit & ((op_in == PUSH) | (op_in == POP));

  // Dropping the lowest set bit retires the register just acknowledged.
  assign rem_next  = rem & (rem - 9'd1);
  assign scan_mask = (state == IDLE) ? {ext_eff, reg_list} : rem_next;
  assign scan_op   = (state == IDLE) ? op_in : op_q;
  assign span      = AW'({scan_cnt, 2'b00});

  reg_list_scan u_scan (
    .mask  (scan_mask),
    .op    (scan_op),
    .idx   (scan_idx),
    .cnt   (scan_cnt),
    .empty (scan_empty)
  );

`ifdef LSM_SEQ_FAULT_EN
  assign ack_err = mem_err;
`else
  assign ack_err = 1'b0;
`endif

  // Load data goes straight to the register file in the ack cycle; base writeback is registered.
  assign load_we   = mem_req & ~mem_we & mem_ack & ~ack_err;
  assign rf_we     = load_we | wb_we;
  assign rf_waddr  = load_we ? rf_raddr : wb_addr;
  assign rf_wdata  = load_we ? mem_rdata : wb_data;
  assign mem_wdata = rf_rdata;

  // Sequencer FSM with registered handshake and writeback outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= STM;
      rem        <= '0;
      base_idx_q <= '0;
      final_base <= '0;
      wb_allow   <= 1'b0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      rf_raddr   <= '0;
`ifdef LSM_SEQ_FAULT_EN
      fault      <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
`ifdef LSM_SEQ_FAULT_EN
      fault   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            op_q       <= op_in;
            base_idx_q <= base_idx;
            rem        <= scan_mask;
            // LDM that reloads its own base keeps the loaded value.
            wb_allow   <= !((op_in == LDM) && !base_idx[3] && reg_list[base_idx[2:0]]);
            if (scan_empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= XFER;
              mem_req  <= 1'b1;
              mem_we   <= is_store(op_in);
              rf_raddr <= scan_idx;
              if (op_in == PUSH) begin
                mem_addr   <= {base_val[AW-1:2], 2'b00} - span;
                final_base <= base_val - span;
              end else begin
                mem_addr   <= {base_val[AW-1:2], 2'b00};
                final_base <= base_val + span;
              end
            end
          end
        end
        XFER: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + AW'(4);
            rem      <= rem_next;
            rf_raddr <= scan_idx;
            if (ack_err) begin
              state   <= DONE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
`ifdef LSM_SEQ_FAULT_EN
              fault   <= 1'b1;
`endif
            end else if (scan_empty) begin
              state   <= WB;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              if (wb_allow) begin
                wb_we   <= 1'b1;
                wb_addr <= base_idx_q;
                wb_data <= DW'(final_base);
              end
            end
          end
        end
        WB: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: memory/register-file models plus a transfer-list reference.
module tb_lsm_sequencer;
  import lsm_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, ext_bit, busy, done, mem_req, mem_we, mem_ack, rf_we;
  logic [1:0]  op;
  logic [7:0]  reg_list;
  logic [3:0]  base_idx, rf_raddr, rf_waddr;
  logic [31:0] base_val, mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata;
`ifdef LSM_SEQ_FAULT_EN
  logic        mem_err, fault;
`endif

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } mrec_t;
  typedef struct packed { logic [3:0] idx; logic [31:0] data; } rrec_t;

  mrec_t       mq[$];
  rrec_t       rq[$];
  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  int          err_at    = -1;
  int          pass_cnt  = 0;
  int          check_cnt = 0;

  always #5 clk = ~clk;

  lsm_sequencer #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reg_list(reg_list),
    .ext_bit(ext_bit), .base_idx(base_idx), .base_val(base_val),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef LSM_SEQ_FAULT_EN
    .mem_err(mem_err), .fault(fault),
`endif
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  assign rf_rdata = rf[rf_raddr];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, logs every completed transfer.
  initial begin : responder
    int          wait_cnt;
    logic [31:0] first_addr;
    wait_cnt = 0; first_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
`ifdef LSM_SEQ_FAULT_EN
    mem_err = 1'b0;
`endif
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
`ifdef LSM_SEQ_FAULT_EN
      mem_err = 1'b0;
`endif
      if (mem_req === 1'b1) begin
        if (wait_cnt == 0) first_addr = mem_addr;
        if (wait_cnt >= ack_delay) begin
          if (ack_delay > 0) begin
            check_cnt++;
            if (mem_addr !== first_addr)
              $display("FAIL addr_stable: got %h want %h", mem_addr, first_addr);
            else pass_cnt++;
          end
          mem_ack   = 1'b1;
          mem_rdata = mem_read(mem_addr);
`ifdef LSM_SEQ_FAULT_EN
          if (err_at >= 0 && mq.size() == err_at) mem_err = 1'b1;
`endif
          mq.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : mem_rdata)});
          if (mem_we) mem[mem_addr] = mem_wdata;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Register-file model: logs and applies every write.
  initial begin : rf_monitor
    for (int i = 0; i < 16; i++) rf[i] = $urandom();
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        rq.push_back({rf_waddr, rf_wdata});
        rf[rf_waddr] = rf_wdata;
      end
    end
  end

  // Launch one operation, predict its transfers from the list rules, and compare.
  task automatic run_op(input string name, input lsm_op_t o, input logic [7:0] lst,
                        input logic ex, input logic [3:0] bi, input logic [31:0] bv,
                        input int dly, input int err, input logic respur);
    int          regs[$];
    mrec_t       em[$];
    rrec_t       er[$];
    int          n, nx, ecyc, cyc;
    logic [31:0] sa, fin, rd, addr;
    logic        got, wb;
    for (int i = 0; i < 8; i++) if (lst[i]) regs.push_back(i);
    if (ex && (o == PUSH || o == POP)) regs.push_back(o == POP ? 15 : 14);
    n   = regs.size();
    sa  = (o == PUSH) ? bv - 32'(4 * n) : bv;
    fin = (o == PUSH) ? bv - 32'(4 * n) : bv + 32'(4 * n);
    nx  = (err >= 0) ? err + 1 : n;
    for (int k = 0; k < nx; k++) begin
      addr = sa + 32'(4 * k);
      if (o == STM || o == PUSH) begin
        em.push_back({1'b1, addr, rf[regs[k]]});
      end else begin
        rd = mem_read(addr);
        em.push_back({1'b0, addr, rd});
        if (k != err) er.push_back({4'(regs[k]), rd});
      end
    end
    wb = (n > 0) && (err < 0) && !(o == LDM && bi < 4'd8 && lst[bi[2:0]]);
    if (wb) er.push_back({bi, fin});
    if (n == 0) ecyc = 1;
    else if (err >= 0) ecyc = nx * (dly + 1) + 1;
    else ecyc = n * (dly + 1) + 2;

    mq.delete(); rq.delete(); ack_delay = dly; err_at = err;
    @(negedge clk);
    op = o; reg_list = lst; ext_bit = ex; base_idx = bi; base_val = bv; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk); cyc++;
      start = respur && (cyc == 1);
      if (respur) begin
        op = 2'($urandom()); reg_list = 8'($urandom()); ext_bit = 1'($urandom());
        base_idx = 4'($urandom()); base_val = $urandom();
      end
      if (done === 1'b1) got = 1'b1;
    end
    check_cnt++;
    if (!got || cyc != ecyc) $display("FAIL %s done_cycle: got %0d (seen=%b) want %0d", name, cyc, got, ecyc);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_at_done: got %b want 1", name, busy);
    else pass_cnt++;
`ifdef LSM_SEQ_FAULT_EN
    check_cnt++;
    if (fault !== 1'(err >= 0)) $display("FAIL %s fault: got %b want %b", name, fault, (err >= 0));
    else pass_cnt++;
`endif
    @(negedge clk);
    start = 1'b0;
    check_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL %s busy_after: got busy=%b done=%b want 0 0", name, busy, done);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (mem_req !== 1'b0) $display("FAIL %s no_relaunch: got mem_req=%b want 0", name, mem_req);
    else pass_cnt++;
    check_cnt++;
    if (mq.size() != em.size()) $display("FAIL %s mem_count: got %0d want %0d", name, mq.size(), em.size());
    else pass_cnt++;
    for (int i = 0; i < em.size() && i < mq.size(); i++) begin
      check_cnt++;
      if (mq[i] !== em[i])
        $display("FAIL %s mem[%0d]: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                 name, i, mq[i].we, mq[i].addr, mq[i].data, em[i].we, em[i].addr, em[i].data);
      else pass_cnt++;
    end
    check_cnt++;
    if (rq.size() != er.size()) $display("FAIL %s rf_count: got %0d want %0d", name, rq.size(), er.size());
    else pass_cnt++;
    for (int i = 0; i < er.size() && i < rq.size(); i++) begin
      check_cnt++;
      if (rq[i] !== er[i])
        $display("FAIL %s rf[%0d]: got r%0d=%h want r%0d=%h", name, i, rq[i].idx, rq[i].data, er[i].idx, er[i].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({busy, done, mem_req, mem_we, mem_addr, rf_raddr, rf_we, rf_waddr, rf_wdata} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b we=%b addr=%h raddr=%h rf_we=%b want all 0",
               busy, done, mem_req, mem_we, mem_addr, rf_raddr, rf_we);
    else pass_cnt++;
`ifdef LSM_SEQ_FAULT_EN
    check_cnt++;
    if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault);
    else pass_cnt++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_stm();
    run_op("stm", STM, 8'h0B, 1'b0, 4'd5, 32'h2000_0100, 0, -1, 1'b0);
  endtask

  task automatic test_push();
    run_op("push", PUSH, 8'h11, 1'b1, SP_IDX, 32'h2000_1000, 0, -1, 1'b0);
  endtask

  task automatic test_pop_wait();
    run_op("pop_wait", POP, 8'h04, 1'b1, SP_IDX, 32'h2000_2000, 2, -1, 1'b0);
  endtask

  task automatic test_ldm_base();
    run_op("ldm_base", LDM, 8'h06, 1'b0, 4'd1, 32'h2000_3000, 0, -1, 1'b0);
  endtask

  task automatic test_empty_restart();
    run_op("empty", STM, 8'h00, 1'b0, 4'd3, 32'h2000_4000, 0, -1, 1'b1);
  endtask

  task automatic test_reset_abort();
    mq.delete(); rq.delete(); ack_delay = 0; err_at = -1;
    @(negedge clk);
    op = STM; reg_list = 8'h0F; ext_bit = 1'b0; base_idx = 4'd9; base_val = 32'h3000_0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (mq.size() != 2) $display("FAIL abort_progress: got %0d transfers want 2", mq.size());
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({busy, done, mem_req, mem_we, mem_addr, rf_raddr, rf_we} !== '0)
      $display("FAIL abort_outputs: got busy=%b done=%b req=%b addr=%h rf_we=%b want all 0",
               busy, done, mem_req, mem_addr, rf_we);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (mq.size() != 2 || rq.size() != 0)
      $display("FAIL abort_quiet: got %0d transfers %0d rf writes want 2 0", mq.size(), rq.size());
    else pass_cnt++;
    run_op("push_after_reset", PUSH, 8'hA5, 1'b1, SP_IDX, 32'h2000_8000, 1, -1, 1'b0);
  endtask

`ifdef LSM_SEQ_FAULT_EN
  task automatic test_fault();
    run_op("pop_err", POP, 8'h0E, 1'b0, SP_IDX, 32'h2000_5000, 1, 1, 1'b0);
  endtask
`endif

  task automatic test_random();
    lsm_op_t     o;
    logic [3:0]  bi;
    for (int t = 0; t < 24; t++) begin
      o  = lsm_op_t'($urandom_range(0, 3));
      bi = (o == PUSH || o == POP) ? SP_IDX : 4'($urandom_range(0, 12));
      run_op("random", o, 8'($urandom()), 1'($urandom()), bi, $urandom() & 32'hFFFF_FFFC,
             $urandom_range(0, 2), -1, 1'($urandom()));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; reg_list = '0; ext_bit = 1'b0;
    base_idx = '0; base_val = '0;
    test_reset();
    test_stm();
    test_push();
    test_pop_wait();
    test_ldm_base();
    test_empty_restart();
    test_reset_abort();
`ifdef LSM_SEQ_FAULT_EN
    test_fault();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
